// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, product arbitration, timed release, greedy change payout.
// Optional hopper-ack watchdog enabled by defining VEND_TIMEOUT_EN.
module vend_controller #(
  parameter int unsigned PRICE1      = 3,
  parameter int unsigned PRICE2      = 5,
  parameter int unsigned PRICE3      = 7,
  parameter int unsigned CREDIT_MAX  = 31,
  parameter int unsigned CREDIT_W    = 5,
  parameter int unsigned VEND_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                BTN1,
  input  logic                BTN2,
  input  logic                BTN3,
  input  logic                cancel,
  input  logic [2:0]          Money_in,
  input  logic                coin_ack,
  output logic                product1,
  output logic                product2,
  output logic                product3,
  output logic                delivered,
  output logic [2:0]          Money_out,
  output logic                coin_req,
  output logic                coin_reject,
  output logic                LED1,
  output logic                LED2,
  output logic                LED3,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                fault
);

  typedef enum logic [2:0] {
    IDLE, VEND, CHG_SEL, CHG_WAIT, CHG_GAP, DONE, FAULT
  } state_t;

  localparam int unsigned VW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

  if (CREDIT_MAX >= (1 << CREDIT_W) || VEND_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_bad_params
    $error("vend_controller: invalid parameter set");
  end

  state_t        state;
  logic [2:0]    money_prev;
  logic [2:0]    btn_prev;
  logic          cancel_prev;
  logic [VW-1:0] vcnt;
  logic          sale;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`endif

  logic                coin_ev;
  logic                cancel_ev;
  logic [2:0]          btn_ev;
  logic [2:0]          coin_val;
  logic [CREDIT_W:0]   sum;
  logic                coin_ok;
  logic [1:0]          pick;
  logic [CREDIT_W-1:0] price_sel;
  logic [2:0]          change_code;
  logic [2:0]          paid_val;

  always_comb begin
    coin_ev   = (money_prev == 3'b000) && (Money_in != 3'b000);
    cancel_ev = cancel && !cancel_prev;
    btn_ev    = {BTN3, BTN2, BTN1} & ~btn_prev;

    unique case (Money_in)
      3'b001:  coin_val = 3'd1;
      3'b010:  coin_val = 3'd2;
      3'b100:  coin_val = 3'd5;
      default: coin_val = 3'd0;
    endcase
    sum     = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
    coin_ok = (coin_val != 3'd0) && (sum <= (CREDIT_W+1)'(CREDIT_MAX));

    // Button priority is resolved before the affordability test, so an
    // unaffordable higher-priority press masks a lower one.
    if (btn_ev[0]) begin
      pick      = 2'd1;
      price_sel = CREDIT_W'(PRICE1);
    end else if (btn_ev[1]) begin
      pick      = 2'd2;
      price_sel = CREDIT_W'(PRICE2);
    end else if (btn_ev[2]) begin
      pick      = 2'd3;
      price_sel = CREDIT_W'(PRICE3);
    end else begin
      pick      = 2'd0;
      price_sel = '0;
    end

    if (credit >= CREDIT_W'(5))      change_code = 3'b100;
    else if (credit >= CREDIT_W'(2)) change_code = 3'b010;
    else                             change_code = 3'b001;

    unique case (Money_out)
      3'b001:  paid_val = 3'd1;
      3'b010:  paid_val = 3'd2;
      3'b100:  paid_val = 3'd5;
      default: paid_val = 3'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      money_prev  <= '0;
      btn_prev    <= '0;
      cancel_prev <= 1'b0;
      vcnt        <= '0;
      sale        <= 1'b0;
      credit      <= '0;
      product1    <= 1'b0;
      product2    <= 1'b0;
      product3    <= 1'b0;
      delivered   <= 1'b0;
      Money_out   <= '0;
      coin_req    <= 1'b0;
      coin_reject <= 1'b0;
      LED1        <= 1'b0;
      LED2        <= 1'b0;
      LED3        <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      tcnt        <= '0;
`endif
    end else begin
      money_prev  <= Money_in;
      btn_prev    <= {BTN3, BTN2, BTN1};
      cancel_prev <= cancel;
      coin_reject <= coin_ev && (state != IDLE);
      delivered   <= 1'b0;
      LED1        <= (state == IDLE) && (credit >= CREDIT_W'(PRICE1));
      LED2        <= (state == IDLE) && (credit >= CREDIT_W'(PRICE2));
      LED3        <= (state == IDLE) && (credit >= CREDIT_W'(PRICE3));

      unique case (state)
        IDLE: begin
          if (cancel_ev && credit != '0) begin
            state       <= CHG_SEL;
            busy        <= 1'b1;
            sale        <= 1'b0;
            coin_reject <= coin_ev;
          end else if (pick != 2'd0 && credit >= price_sel) begin
            state       <= VEND;
            busy        <= 1'b1;
            sale        <= 1'b1;
            credit      <= credit - price_sel;
            vcnt        <= VW'(VEND_CYCLES - 1);
            product1    <= (pick == 2'd1);
            product2    <= (pick == 2'd2);
            product3    <= (pick == 2'd3);
            coin_reject <= coin_ev;
          end else if (coin_ev) begin
            if (coin_ok) credit <= sum[CREDIT_W-1:0];
            else         coin_reject <= 1'b1;
          end
        end
        VEND: begin
          if (vcnt == '0) begin
            product1 <= 1'b0;
            product2 <= 1'b0;
            product3 <= 1'b0;
            if (credit == '0) begin
              state     <= DONE;
              delivered <= 1'b1;
            end else begin
              state <= CHG_SEL;
            end
          end else begin
            vcnt <= vcnt - VW'(1);
          end
        end
        CHG_SEL: begin
          Money_out <= change_code;
          coin_req  <= 1'b1;
          state     <= CHG_WAIT;
`ifdef VEND_TIMEOUT_EN
          tcnt      <= '0;
`endif
        end
        CHG_WAIT: begin
          if (coin_ack) begin
            credit   <= credit - CREDIT_W'(paid_val);
            coin_req <= 1'b0;
            state    <= CHG_GAP;
          end
`ifdef VEND_TIMEOUT_EN
          else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
            coin_req  <= 1'b0;
            Money_out <= '0;
            fault     <= 1'b1;
            state     <= FAULT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        CHG_GAP: begin
          if (!coin_ack) begin
            Money_out <= '0;
            if (credit != '0) begin
              state <= CHG_SEL;
            end else if (sale) begin
              state     <= DONE;
              delivered <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        FAULT: state <= FAULT;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
